shift_unit: RTL and testbench

- Multi-cycle, parametrised shifter for the datapath's R-type shift group (SLL, SRL, SRA, their variable forms, and rotates).
- Takes over shift-amount selection, previously a combinational mux, and performs the shift iteratively, STEP bits per cycle, under a start/done handshake.
- Sits beside the ALU; the control unit stalls on `busy` and captures `result` on `done`.

---
 rtl/shift_pkg.sv | 27 ++
 rtl/shift_amount_sel.sv | 50 +++++
 rtl/shift_unit.sv | 128 ++++++++++++
 tb/tb_shift_unit.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared decode constants and enums for the iterative shifter.
package shift_pkg;

  localparam logic [5:0] FN_SLL   = 6'b000000;
  localparam logic [5:0] FN_ROTR  = 6'b000001;
  localparam logic [5:0] FN_SRL   = 6'b000010;
  localparam logic [5:0] FN_SRA   = 6'b000011;
  localparam logic [5:0] FN_SLLV  = 6'b000100;
  localparam logic [5:0] FN_ROTRV = 6'b000101;
  localparam logic [5:0] FN_SRLV  = 6'b000110;
  localparam logic [5:0] FN_SRAV  = 6'b000111;

  typedef enum logic [1:0] {
    OP_SLL,
    OP_SRL,
    OP_SRA,
    OP_ROR
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE,
    S_ERR
  } state_e;

endpackage

// File: rtl/shift_amount_sel.sv
// Decodes funct into a shift op and selects the shift amount (immediate or rs-based).
module shift_amount_sel
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter bit          SAT_VAR = 1'b1,
  localparam int unsigned SHW    = $clog2(WIDTH),
  localparam int unsigned AW     = SHW + 1
) (
  input  logic [15:0]      instr,
  input  logic [WIDTH-1:0] reg_a,
  output op_e              op,
  output logic [AW-1:0]    amount,
  output logic             illegal
);

  logic [5:0]    w_funct;
  logic [AW-1:0] w_imm;
  logic [AW-1:0] w_mod;
  logic [AW-1:0] w_var;
  logic          w_big;
  logic          w_unused;

  assign w_funct  = instr[5:0];
  assign w_imm    = AW'(instr[10:6]);
  assign w_mod    = {1'b0, reg_a[SHW-1:0]};
  assign w_big    = |reg_a[WIDTH-1:SHW];
  // Out-of-range variable amounts clamp to WIDTH so the shift empties the operand.
  assign w_var    = (SAT_VAR && w_big) ? AW'(WIDTH) : w_mod;
  assign w_unused = ^instr[15:11];

  always_comb begin
    op      = OP_SLL;
    amount  = '0;
    illegal = 1'b0;
    case (w_funct)
      FN_SLL:   begin op = OP_SLL; amount = w_imm; end
      FN_SRL:   begin op = OP_SRL; amount = w_imm; end
      FN_SRA:   begin op = OP_SRA; amount = w_imm; end
      FN_ROTR:  begin op = OP_ROR; amount = w_imm; end
      FN_SLLV:  begin op = OP_SLL; amount = w_var; end
      FN_SRLV:  begin op = OP_SRL; amount = w_var; end
      FN_SRAV:  begin op = OP_SRA; amount = w_var; end
      // Rotates never saturate: the amount is always taken modulo WIDTH.
      FN_ROTRV: begin op = OP_ROR; amount = w_mod; end
      default:  illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/shift_unit.sv
// Multi-cycle shifter: shifts STEP bits per cycle under a start/done handshake.
module shift_unit
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned STEP    = 1,
  parameter bit          SAT_VAR = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [15:0]      instr,
  input  logic [WIDTH-1:0] reg_a,
  input  logic [WIDTH-1:0] data_in,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned SHW = $clog2(WIDTH);
  localparam int unsigned AW  = SHW + 1;

  state_e           r_state;
  op_e              r_op;
  logic [AW-1:0]    r_rem;
  logic             r_sign;
  logic             r_busy;
  logic             r_done;
  logic             r_err;
  logic [WIDTH-1:0] r_result;

  op_e              w_op;
  logic [AW-1:0]    w_amount;
  logic             w_illegal;
  logic [AW-1:0]    w_k;
  logic [WIDTH-1:0] w_shifted;

  shift_amount_sel #(
    .WIDTH   (WIDTH),
    .SAT_VAR (SAT_VAR)
  ) u_amount_sel (
    .instr   (instr),
    .reg_a   (reg_a),
    .op      (w_op),
    .amount  (w_amount),
    .illegal (w_illegal)
  );

  // One STEP-wide shift stage; the final step may be shorter than STEP.
  always_comb begin
    w_k       = (r_rem > AW'(STEP)) ? AW'(STEP) : r_rem;
    w_shifted = r_result;
    case (r_op)
      OP_SLL:  w_shifted = r_result << w_k;
      OP_SRL:  w_shifted = r_result >> w_k;
      OP_SRA:  w_shifted = (r_result >> w_k) |
                           (~({WIDTH{1'b1}} >> w_k) & {WIDTH{r_sign}});
      OP_ROR:  w_shifted = (r_result >> w_k) | (r_result << (AW'(WIDTH) - w_k));
      default: w_shifted = r_result;
    endcase
  end

  // Control FSM; result doubles as the working shift register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_op     <= OP_SLL;
      r_rem    <= '0;
      r_sign   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_result <= '0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_busy <= 1'b0;
          if (start) begin
            r_busy <= 1'b1;
            if (w_illegal) begin
              r_state <= S_ERR;
              r_err   <= 1'b1;
            end else if (w_amount == '0) begin
              r_state  <= S_DONE;
              r_done   <= 1'b1;
              r_result <= data_in;
            end else begin
              r_state  <= S_SHIFT;
              r_result <= data_in;
              r_op     <= w_op;
              r_rem    <= w_amount;
              r_sign   <= data_in[WIDTH-1];
            end
          end
        end
        S_SHIFT: begin
          r_result <= w_shifted;
          r_rem    <= r_rem - w_k;
          if (r_rem == w_k) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        S_ERR: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign err    = r_err;
  assign result = r_result;

endmodule

// File: tb/tb_shift_unit.sv
// Randomized bench: three shift_unit configurations share stimulus and are checked against a reference model.
module tb_shift_unit;

  localparam int N = 3;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] instr;
  logic [31:0] reg_a;
  logic [31:0] data_in;

  logic [N-1:0] busy_v;
  logic [N-1:0] done_v;
  logic [N-1:0] err_v;
  logic [31:0]  res_v [N];

  int          steps [N];
  bit          sats  [N];
  logic [31:0] exp_res [N];

  int n_chk;
  int n_fail;

  shift_unit #(.WIDTH(32), .STEP(1), .SAT_VAR(1'b1)) u_d0 (
    .clk(clk), .reset(reset), .start(start), .instr(instr), .reg_a(reg_a),
    .data_in(data_in), .busy(busy_v[0]), .done(done_v[0]), .err(err_v[0]), .result(res_v[0]));

  shift_unit #(.WIDTH(32), .STEP(1), .SAT_VAR(1'b0)) u_d1 (
    .clk(clk), .reset(reset), .start(start), .instr(instr), .reg_a(reg_a),
    .data_in(data_in), .busy(busy_v[1]), .done(done_v[1]), .err(err_v[1]), .result(res_v[1]));

  shift_unit #(.WIDTH(32), .STEP(4), .SAT_VAR(1'b1)) u_d2 (
    .clk(clk), .reset(reset), .start(start), .instr(instr), .reg_a(reg_a),
    .data_in(data_in), .busy(busy_v[2]), .done(done_v[2]), .err(err_v[2]), .result(res_v[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference: amount from the decode rules, result from plain arithmetic, latency from ceil(A/STEP)+1.
  function automatic void model(input logic [15:0] ins, input logic [31:0] ra, input logic [31:0] din,
                                input int step, input bit sat, input logic [31:0] prev,
                                output logic [31:0] res, output int cyc, output bit is_err);
    logic [5:0]  fn;
    int unsigned amt;
    logic [63:0] dbl;
    fn     = ins[5:0];
    is_err = 1'b0;
    res    = prev;
    amt    = 0;
    case (fn)
      6'h00, 6'h01, 6'h02, 6'h03: amt = ins[10:6];
      6'h04, 6'h06, 6'h07: amt = (sat && ra > 32'd31) ? 32 : ra % 32;
      6'h05: amt = ra % 32;
      default: is_err = 1'b1;
    endcase
    if (is_err) begin
      cyc = 1;
    end else begin
      cyc = (amt == 0) ? 1 : (int'(amt) + step - 1) / step + 1;
      case (fn)
        6'h00, 6'h04: res = (amt >= 32) ? 32'h0 : din << amt;
        6'h02, 6'h06: res = (amt >= 32) ? 32'h0 : din >> amt;
        6'h03, 6'h07: res = (amt >= 32) ? {32{din[31]}} : 32'($signed(din) >>> amt);
        default: begin
          dbl = {din, din} >> (amt % 32);
          res = dbl[31:0];
        end
      endcase
    end
  endfunction

  task automatic run_op(input logic [15:0] ins, input logic [31:0] ra, input logic [31:0] din);
    int          cyc [N];
    bit          er  [N];
    logic [31:0] nr  [N];
    int          maxc;
    maxc = 0;
    for (int i = 0; i < N; i++) begin
      model(ins, ra, din, steps[i], sats[i], exp_res[i], nr[i], cyc[i], er[i]);
      if (cyc[i] > maxc) maxc = cyc[i];
    end
    instr   = ins;
    reg_a   = ra;
    data_in = din;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    instr   = 16'($urandom);
    reg_a   = $urandom;
    data_in = $urandom;
    for (int n = 1; n <= maxc + 1; n++) begin
      for (int i = 0; i < N; i++) begin
        chk($sformatf("flags d%0d f=%0h c%0d", i, ins[5:0], n),
            64'({busy_v[i], done_v[i], err_v[i]}),
            64'({n <= cyc[i], (n == cyc[i]) && !er[i], (n == cyc[i]) && er[i]}));
        if (n == cyc[i] || n == maxc + 1)
          chk($sformatf("result d%0d f=%0h c%0d", i, ins[5:0], n), 64'(res_v[i]), 64'(nr[i]));
      end
      if (n <= maxc) begin
        @(posedge clk);
        #1;
      end
    end
    for (int i = 0; i < N; i++) exp_res[i] = nr[i];
  endtask

  function automatic logic [15:0] mk(input logic [4:0] sh, input logic [5:0] fn);
    return {5'd0, sh, fn};
  endfunction

  initial begin
    logic [5:0] legal [8];
    logic [5:0] fn;
    logic [31:0] ra;
    n_chk   = 0;
    n_fail  = 0;
    steps   = '{1, 1, 4};
    sats    = '{1'b1, 1'b0, 1'b1};
    legal   = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07};
    for (int i = 0; i < N; i++) exp_res[i] = 32'h0;

    // Reset with start held high: the request must be dropped.
    reset   = 1'b0;
    start   = 1'b1;
    instr   = mk(5'd4, 6'h00);
    reg_a   = 32'h0;
    data_in = 32'hF1;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      chk($sformatf("reset d%0d", i),
          64'({busy_v[i], done_v[i], err_v[i], res_v[i]}), 64'h0);
    reset = 1'b1;
    start = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      chk($sformatf("post_reset idle d%0d", i), 64'({busy_v[i], done_v[i], err_v[i]}), 64'h0);

    run_op(mk(5'd4, 6'h00), 32'h0, 32'h0000_00F1);
    chk("tp sll result", 64'(res_v[0]), 64'h0000_0F10);
    run_op(16'h0007, 32'h0000_0100, 32'h8000_0000);
    chk("tp srav sat", 64'(res_v[0]), 64'hFFFF_FFFF);
    chk("tp srav mod", 64'(res_v[1]), 64'h8000_0000);
    run_op(16'h0005, 32'h0000_0025, 32'h0000_0013);
    chk("tp rotrv", 64'(res_v[2]), 64'h9800_0000);
    run_op(16'h0020, 32'h0, 32'h1234_5678);
    chk("tp err keeps result", 64'(res_v[2]), 64'h9800_0000);

    // Abort an SRL by 8 with reset low during cycle 3.
    instr   = mk(5'd8, 6'h02);
    reg_a   = 32'h0;
    data_in = 32'hDEAD_BEEF;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < N; i++) begin
      chk($sformatf("abort d%0d", i),
          64'({busy_v[i], done_v[i], err_v[i], res_v[i]}), 64'h0);
      exp_res[i] = 32'h0;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      chk($sformatf("abort quiet d%0d", i), 64'({busy_v[i], done_v[i], err_v[i]}), 64'h0);
    run_op(mk(5'd8, 6'h02), 32'h0, 32'hDEAD_BEEF);

    // Randomized operations, including boundary amounts and illegal functs.
    for (int t = 0; t < 40; t++) begin
      fn = ($urandom_range(0, 7) == 0) ? 6'h08 + 6'($urandom_range(0, 50)) : legal[$urandom_range(0, 7)];
      case ($urandom_range(0, 3))
        0:       ra = 32'($urandom_range(0, 40));
        1:       ra = 32'd32;
        2:       ra = 32'd31;
        default: ra = $urandom;
      endcase
      run_op({5'($urandom), 5'($urandom), fn}, ra, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
